// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM-subset controller:
// FSM state encoding, condition codes, data-processing commands and the
// ALUControl encodings, plus a command decoder used by the top level.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  // Instruction classes from Op
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Data-processing commands (Funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // ALUControl encodings (zero-extended to the port width)
  localparam int unsigned ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_W-1:0] ALU_ORR = 3'd3;
  localparam logic [ALU_W-1:0] ALU_EOR = 3'd4;
  localparam logic [ALU_W-1:0] ALU_MOV = 3'd5;

  typedef struct packed {
    logic             valid;     // recognised command
    logic             no_write;  // compare/test: result not written back
    logic             nz_only;   // logical op: only N and Z are updated
    logic [ALU_W-1:0] ctrl;
  } alu_dec_t;

  // Map a data-processing command to its ALU operation and write-back attributes
  function automatic alu_dec_t decode_cmd(input logic [3:0] cmd);
    alu_dec_t d;
    d.valid    = 1'b1;
    d.no_write = 1'b0;
    d.nz_only  = 1'b0;
    d.ctrl     = ALU_ADD;
    case (cmd)
      CMD_ADD: d.ctrl = ALU_ADD;
      CMD_SUB: d.ctrl = ALU_SUB;
      CMD_AND: begin d.ctrl = ALU_AND; d.nz_only = 1'b1; end
      CMD_ORR: begin d.ctrl = ALU_ORR; d.nz_only = 1'b1; end
      CMD_EOR: begin d.ctrl = ALU_EOR; d.nz_only = 1'b1; end
      CMD_CMP: begin d.ctrl = ALU_SUB; d.no_write = 1'b1; end
      CMD_TST: begin d.ctrl = ALU_AND; d.no_write = 1'b1; d.nz_only = 1'b1; end
      CMD_MOV: begin d.ctrl = ALU_MOV; d.nz_only = 1'b1; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Evaluates an ARM condition field against the stored NZCV flags.
// Condition 1111 never passes.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = Flags;

  // Combinational condition check
  always_comb begin
    pass = 1'b0;
    case (Cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: sequencing FSM, flag register,
// condition latch and per-state datapath control.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,  // must be at least 3
  parameter bit MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl
);

  // Instruction fields (port bit i is instruction bit i+12)
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_instr;
  assign cond         = Instr[19:16];
  assign op           = Instr[15:14];
  assign funct        = Instr[13:8];
  assign unused_instr = ^Instr[7:0];

  logic mem_ready;
  assign mem_ready = MEM_WAIT ? MemReady : 1'b1;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_pass;
  alu_dec_t   dec;
  logic       in_exec;

  assign dec     = decode_cmd(funct[4:1]);
  assign in_exec = (state_q == EXECR) || (state_q == EXECI);

  cond_unit u_cond (
    .Cond  (cond),
    .Flags (flags_q),
    .pass  (cond_pass)
  );

  // State, flags and condition latch; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Condition is frozen at DECODE so this instruction's own flag update cannot regate it
  always_comb begin
    cond_ex_d = (state_q == DECODE) ? cond_pass : cond_ex_q;
  end

  // Flag capture at the end of the execute cycle
  always_comb begin
    flags_d = flags_q;
    if (in_exec && funct[0] && cond_ex_q && dec.valid) begin
      if (dec.nz_only) flags_d[3:2] = ALUFlags[3:2];
      else             flags_d      = ALUFlags;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_DP:   state_d = funct[5] ? EXECI : EXECR;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR,
      EXECI:    state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  logic             pc_write_raw, mem_write_raw, reg_write_raw, ir_write_raw;
  logic [ALU_W-1:0] alu_sel;

  // Per-state datapath selects and unqualified strobes
  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    AdrSrc        = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    alu_sel       = ALU_ADD;
    case (state_q)
      FETCH: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = cond_ex_q;
      end
      MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = cond_ex_q;
      end
      EXECR:    alu_sel = dec.ctrl;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_sel = dec.ctrl;
      end
      ALUWB:    reg_write_raw = cond_ex_q & dec.valid & ~dec.no_write;
      BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ResultSrc    = 2'b10;
        pc_write_raw = cond_ex_q;
      end
      default: ;
    endcase
  end

  // Strobes are forced low for as long as reset is held
  assign PCWrite  = pc_write_raw  & reset;
  assign MemWrite = mem_write_raw & reset;
  assign RegWrite = reg_write_raw & reset;
  assign IRWrite  = ir_write_raw  & reset;

  assign ImmSrc     = op;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};
  assign ALUControl = ALUCTRL_W'(alu_sel);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a table of whole instructions with
// hand-computed strobe counts and flag results, plus hand-written
// sequences for memory wait states and reset during a store.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;

  mc_controller #(.ALUCTRL_W(3), .MEM_WAIT(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    int          cycles;
    int          rw;
    int          mw;
    int          bpc;    // PCWrite pulses besides the fetch
    int          alu;    // ALUControl in the execute cycle, -1 = not checked
    logic [3:0]  flags;  // flag register after the instruction
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  // Runs one instruction with MemReady=1 from FETCH back to FETCH; call at a falling edge
  task automatic run_vec(input vec_t v);
    int cyc = 0, rw = 0, mw = 0, pc = 0, irw = 0, alu = -1, alu_bad = 0;
    Instr    = v.instr;
    ALUFlags = v.alu_flags;
    MemReady = 1'b1;
    do begin
      #1;
      if (RegWrite) rw++;
      if (MemWrite) mw++;
      if (PCWrite)  pc++;
      if (IRWrite)  irw++;
      if (dut.state_q == EXECR || dut.state_q == EXECI) alu = int'(ALUControl);
      else if (ALUControl != 3'd0) alu_bad++;
      cyc++;
      @(negedge clk);
    end while (dut.state_q != FETCH && cyc < 20);
    chk({v.name, " cycles"},   cyc, v.cycles);
    chk({v.name, " RegWrite"}, rw,  v.rw);
    chk({v.name, " MemWrite"}, mw,  v.mw);
    chk({v.name, " PCWrite"},  pc,  1 + v.bpc);
    chk({v.name, " IRWrite"},  irw, 1);
    if (v.alu >= 0) chk({v.name, " ALUControl"}, alu, v.alu);
    chk({v.name, " ALUControl idle"}, alu_bad, 0);
    chk({v.name, " Flags"}, int'(dut.flags_q), int'(v.flags));
    $display("[TB] %s instr=%05h cycles=%0d rw=%0d mw=%0d pc=%0d alu=%0d flags=%04b",
             v.name, v.instr, cyc, rw, mw, pc, alu, dut.flags_q);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    //           name      instr      aluflg   cyc rw mw bpc alu flags
    vecs[0]  = '{"ADD",    20'hE2821, 4'b0000, 4, 1, 0, 0,  0, 4'b0000};
    vecs[1]  = '{"SUBS",   20'hE2511, 4'b0100, 4, 1, 0, 0,  1, 4'b0100};
    vecs[2]  = '{"BEQ",    20'h0A000, 4'b0000, 3, 0, 0, 1, -1, 4'b0100};
    vecs[3]  = '{"BNE",    20'h1A000, 4'b0000, 3, 0, 0, 0, -1, 4'b0100};
    vecs[4]  = '{"ORRNES", 20'h13911, 4'b1010, 4, 0, 0, 0,  3, 4'b0100};
    vecs[5]  = '{"CMP",    20'hE1510, 4'b1000, 4, 0, 0, 0,  1, 4'b1000};
    vecs[6]  = '{"ADDS",   20'hE2900, 4'b0011, 4, 1, 0, 0,  0, 4'b0011};
    vecs[7]  = '{"ANDS",   20'hE2100, 4'b1100, 4, 1, 0, 0,  2, 4'b1111};
    vecs[8]  = '{"MOV",    20'hE3A01, 4'b0000, 4, 1, 0, 0,  5, 4'b1111};
    vecs[9]  = '{"BGT",    20'hCA000, 4'b0000, 3, 0, 0, 0, -1, 4'b1111};
    vecs[10] = '{"BLE",    20'hDA000, 4'b0000, 3, 0, 0, 1, -1, 4'b1111};
    vecs[11] = '{"BHI",    20'h8A000, 4'b0000, 3, 0, 0, 0, -1, 4'b1111};
    vecs[12] = '{"BCS",    20'h2A000, 4'b0000, 3, 0, 0, 1, -1, 4'b1111};
    vecs[13] = '{"ADDNV",  20'hF2821, 4'b0000, 4, 0, 0, 0,  0, 4'b1111};
    vecs[14] = '{"UNDEFS", 20'hE2F00, 4'b0000, 4, 0, 0, 0, -1, 4'b1111};
    vecs[15] = '{"OP11",   20'hEC000, 4'b0000, 2, 0, 0, 0, -1, 4'b1111};
    vecs[16] = '{"STR",    20'hE5801, 4'b0000, 4, 0, 1, 0, -1, 4'b1111};
    vecs[17] = '{"LDR",    20'hE5901, 4'b0000, 5, 1, 0, 0, -1, 4'b1111};
    vecs[18] = '{"STREQ",  20'h05801, 4'b0000, 4, 0, 1, 0, -1, 4'b1111};
    vecs[19] = '{"STRNE",  20'h15801, 4'b0000, 4, 0, 0, 0, -1, 4'b1111};
    vecs[20] = '{"EORS",   20'hE2300, 4'b0100, 4, 1, 0, 0,  4, 4'b0111};
    vecs[21] = '{"TST",    20'hE1100, 4'b1000, 4, 0, 0, 0,  2, 4'b1011};

    // Reset state: strobes low even with MemReady high
    reset = 1'b0; MemReady = 1'b1; Instr = 20'hE2821; ALUFlags = 4'b1111;
    #1;
    chk("rst state",    int'(dut.state_q), int'(FETCH));
    chk("rst flags",    int'(dut.flags_q), 0);
    chk("rst PCWrite",  int'(PCWrite),  0);
    chk("rst IRWrite",  int'(IRWrite),  0);
    chk("rst RegWrite", int'(RegWrite), 0);
    chk("rst MemWrite", int'(MemWrite), 0);
    repeat (2) @(negedge clk);
    chk("rst hold state", int'(dut.state_q), int'(FETCH));
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // LDR with fetch stall and three memory wait cycles; flags are 1011 here
    Instr = 20'hE5901; ALUFlags = 4'b0000; MemReady = 1'b0;
    #1;
    chk("ldr fetch wait IRWrite", int'(IRWrite), 0);
    chk("ldr fetch wait PCWrite", int'(PCWrite), 0);
    chk("ldr fetch ALUSrcA",   int'(ALUSrcA),   1);
    chk("ldr fetch ALUSrcB",   int'(ALUSrcB),   2);
    chk("ldr fetch ResultSrc", int'(ResultSrc), 2);
    tick();
    chk("ldr fetch held", int'(dut.state_q), int'(FETCH));
    MemReady = 1'b1; #1;
    chk("ldr fetch IRWrite", int'(IRWrite), 1);
    tick();
    chk("ldr decode", int'(dut.state_q), int'(DECODE));
    chk("ldr RegSrc", int'(RegSrc), 2);
    chk("ldr ImmSrc", int'(ImmSrc), 1);
    tick();
    chk("ldr memadr",  int'(dut.state_q), int'(MEMADR));
    chk("ldr ALUSrcB", int'(ALUSrcB), 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      MemReady = 1'b0; #1;
      chk($sformatf("ldr wait%0d state", k),    int'(dut.state_q), int'(MEMREAD));
      chk($sformatf("ldr wait%0d AdrSrc", k),   int'(AdrSrc),   1);
      chk($sformatf("ldr wait%0d RegWrite", k), int'(RegWrite), 0);
      tick();
    end
    MemReady = 1'b1; #1;
    chk("ldr ready state",  int'(dut.state_q), int'(MEMREAD));
    chk("ldr ready AdrSrc", int'(AdrSrc), 1);
    tick();
    chk("ldr memwb",           int'(dut.state_q), int'(MEMWB));
    chk("ldr memwb RegWrite",  int'(RegWrite),  1);
    chk("ldr memwb ResultSrc", int'(ResultSrc), 1);
    tick();
    chk("ldr back to fetch", int'(dut.state_q), int'(FETCH));
    chk("ldr fetch RegWrite", int'(RegWrite), 0);
    $display("[TB] LDR wait sequence done");

    // STR held in MEMWRITE, then reset asserted mid-access
    Instr = 20'hE5801; MemReady = 1'b1;
    tick();
    tick();
    MemReady = 1'b0;
    tick();
    chk("str memwrite state", int'(dut.state_q), int'(MEMWRITE));
    chk("str MemWrite",       int'(MemWrite), 1);
    MemReady = 1'b1;
    reset = 1'b0;
    #1;
    chk("str rst MemWrite", int'(MemWrite), 0);
    chk("str rst state",    int'(dut.state_q), int'(FETCH));
    chk("str rst flags",    int'(dut.flags_q), 0);
    chk("str rst PCWrite",  int'(PCWrite), 0);
    chk("str rst IRWrite",  int'(IRWrite), 0);
    $display("[TB] reset during MEMWRITE done");
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
